o_buff_reader: RTL
==================

Name: o_buff_reader

Overview:
Drain engine for the PE array output buffer. It is the read-side counterpart of the A/B load path. After a compute pass, it takes a base address and a word count. It then issues enO/addrO reads to the O buffer (1-cycle registered read latency) and serialises each O_BUFF_WIDTH word into OUT_WIDTH beats on a valid/ready output stream. It sits between PE_wrapper's O buffer port and the host/DMA side.

Parameters:
O_BUFF_WIDTH, 64, width of one O buffer word
O_BUFF_DEPTH, 16, number of O buffer words
OUT_WIDTH, 32, stream beat width; O_BUFF_WIDTH must be an integer multiple of it
O_ADDR_WIDTH, width(O_BUFF_DEPTH), O buffer address width
LEN_WIDTH, O_ADDR_WIDTH+1, width of the word-count input

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle request; sampled only in IDLE
base_addr  in  O_ADDR_WIDTH  first O buffer word to read
len  in  LEN_WIDTH  number of O words to read (0 allowed)
enO  out  1  O buffer read enable
addrO  out  O_ADDR_WIDTH  O buffer read address
doutO  in  O_BUFF_WIDTH  O buffer read data, valid the cycle after enO
m_data  out  OUT_WIDTH  stream beat
m_valid  out  1  beat valid
m_ready  in  1  downstream accept
m_last  out  1  high on the final beat of the transfer
busy  out  1  high in all states except IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state is IDLE, FIFO is empty, counters are 0. Deasserting rst mid-transfer does not resume; the block restarts from IDLE.
- FSM states:
  - IDLE: start=1 latches base_addr/len. Next state is RUN if len>0, else DONE.
  - RUN: issues reads. Moves to DRAIN when the last read issues.
  - DRAIN: waits until the FIFO is empty and the serialiser has sent its last beat accepted. Then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; latched base_addr/len do not change.
- Read issue:
  - enO=1 in a cycle only if state is RUN, reads remain, and (FIFO occupancy + reads in flight) < 2.
  - addrO starts at base_addr and increments by 1 per issued read, wrapping modulo O_BUFF_DEPTH.
  - addrO holds its value when enO=0.
- Capture: doutO is written into a 2-entry FIFO one cycle after each enO. Credit accounting guarantees the FIFO never overflows.
- Serialiser:
  - Pops one FIFO word and emits O_BUFF_WIDTH/OUT_WIDTH beats, least-significant slice first (bits OUT_WIDTH-1:0 first).
  - A beat transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays 1.
  - With m_ready held high, there are no bubbles between beats or between words.
- Latency: start sampled at edge k. enO=1 during cycle k+1 with addrO=base_addr. The first m_valid is in cycle k+3.
- m_last=1 only with the final beat of word len-1.
- done asserts in the cycle after the m_last beat is accepted.
- len=0: no enO, no m_valid. done pulses in cycle k+1 and busy=1 only during that cycle.
- len ≥ O_BUFF_DEPTH: addresses wrap and re-read words; no error is flagged.
- m_ready is ignored when m_valid=0.

Test Plan:
1. O[0..3]=0x00000002_00000001, 0x4_3, 0x6_5, 0x8_7; base=0, len=4, m_ready=1 → beats 1,2,3,…,8 on consecutive cycles starting at k+3. m_last is on beat 8, done one cycle later, busy falls with done.
2. Same data with m_ready=1 for 1 cycle then 0 for 2 cycles, repeating → identical beat sequence 1..8 with no loss or duplication. m_data is stable while stalled. Never more than 2 outstanding reads + FIFO entries.
3. base=14, len=4, depth 16 → addrO sequence 14,15,0,1. Beats come in that word order, low half first.
4. len=0 → done pulses at k+1; enO and m_valid stay 0 throughout.
5. Second start pulse mid-transfer with base=5, len=1 → ignored: transfer continues from the original addresses and exactly 2·len beats are output.
6. rst=0 asserted mid-DRAIN with m_valid=1 → m_valid, enO, busy and done go 0 immediately. After release, a new start with base=0, len=1 outputs beats 1,2 correctly.

Source files
------------

// File: rtl/o_buff_reader.sv
// rtl/o_buff_reader.sv - O buffer drain engine: reads words and serialises them onto a beat stream
// Reads are credit-limited to a 2-entry capture FIFO; the head word is sliced into beats LSB first.
module o_buff_reader #(
  parameter int O_BUFF_WIDTH = 64,
  parameter int O_BUFF_DEPTH = 16,
  parameter int OUT_WIDTH    = 32,
  parameter int O_ADDR_WIDTH = $clog2(O_BUFF_DEPTH),
  parameter int LEN_WIDTH    = O_ADDR_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [O_ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    enO,
  output logic [O_ADDR_WIDTH-1:0] addrO,
  input  logic [O_BUFF_WIDTH-1:0] doutO,
  output logic [OUT_WIDTH-1:0]    m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);

  localparam int BEATS  = O_BUFF_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [O_ADDR_WIDTH-1:0] LAST_ADDR = O_ADDR_WIDTH'(O_BUFF_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [O_ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [LEN_WIDTH-1:0]           rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]           wd_left_q, wd_left_d;
  logic                           rd_pend_q, rd_pend_d;
  logic [1:0][O_BUFF_WIDTH-1:0]   fifo_q, fifo_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;

  logic [O_BUFF_WIDTH-1:0]        head;
  logic                           last_beat;
  logic                           beat_fire;
  logic                           pop;
  int                             beat_sh;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_left_d = rd_left_q;
    wd_left_d = wd_left_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    beat_d    = beat_q;

    head      = fifo_q[rd_ptr_q];
    beat_sh   = int'(beat_q) * OUT_WIDTH;
    last_beat = (beat_q == LAST_BEAT);
    m_valid   = (cnt_q != 2'd0);
    m_data    = m_valid ? OUT_WIDTH'(head >> beat_sh) : '0;
    m_last    = m_valid && last_beat && (wd_left_q == LEN_WIDTH'(1));
    beat_fire = m_valid && m_ready;
    pop       = beat_fire && last_beat;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    addrO     = addr_q;

    // A word still being popped this cycle keeps its credit, so the FIFO can never overflow.
    enO = (state_q == S_RUN) && (rd_left_q != '0) &&
          ((cnt_q + {1'b0, rd_pend_q}) < 2'd2);

    if (enO) begin
      addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + O_ADDR_WIDTH'(1);
      rd_left_d = rd_left_q - LEN_WIDTH'(1);
    end
    rd_pend_d = enO;

    if (rd_pend_q) begin
      fifo_d[wr_ptr_q] = doutO;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (beat_fire) begin
      beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      wd_left_d = wd_left_q - LEN_WIDTH'(1);
    end
    cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          rd_left_d = len;
          wd_left_d = len;
          state_d   = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (enO && (rd_left_q == LEN_WIDTH'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_last && m_ready) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_left_q <= '0;
      wd_left_q <= '0;
      rd_pend_q <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_left_q <= rd_left_d;
      wd_left_q <= wd_left_d;
      rd_pend_q <= rd_pend_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
    end
  end

endmodule
